// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD driver.
// Holds the controller and per-byte phase encodings, the HD44780 command
// bytes, the ASCII glyphs used to build a frame and the opcode mnemonic table.
// No ports; imported by lcd_hd44780_driver and bin_to_bcd17.
package lcd_pkg;

    // Controller states
    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_CONV  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Micro-phases of a single bus transfer
    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_EHIGH = 2'd1;
    localparam logic [1:0] P_HOLD  = 2'd2;

    // HD44780 commands
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    // ASCII glyphs
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LBR   = 8'h5B;
    localparam logic [7:0] ASCII_RBR   = 8'h5D;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_X     = 8'h78;

    // Mnemonics indexed by opcode; entry 0 is the rightmost word
    localparam logic [7:0][31:0] MNEMONIC_TABLE = {
        "DPY ", "CLR ", "MUL ", "SUBI", "SUB ", "ADDI", "ADD ", "LOAD"
    };

    // One byte on the LCD bus together with its register-select level
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } xfer_t;

    // Character pos (0 = leftmost) of the mnemonic for opcode op
    function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [1:0] pos);
        logic [31:0] word;
        logic [7:0]  ch;
        word = MNEMONIC_TABLE[op];
        case (pos)
            2'd0:    ch = word[31:24];
            2'd1:    ch = word[23:16];
            2'd2:    ch = word[15:8];
            default: ch = word[7:0];
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/bin_to_bcd17.sv
// Iterative double-dabble converter, 17-bit binary magnitude to 5 BCD digits.
// A start pulse loads the operand (1 cycle), then 17 shift cycles follow;
// done pulses for one cycle together with the final digits, which then stay
// on bcd until the next start.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        one-cycle request, samples bin
//   bin[16:0]    magnitude to convert
//   done         one-cycle pulse, bcd valid from this cycle on
//   bcd[19:0]    digits, [19:16] = ten-thousands ... [3:0] = units
module bin_to_bcd17 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [16:0] bin,
    output logic        done,
    output logic [19:0] bcd
);
    import lcd_pkg::*;

    // Upper 20 bits accumulate digits, lower 17 hold the bits still to shift in
    logic [36:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [36:0] adj;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Each busy cycle corrects digits >= 5 and shifts one bit into the BCD field
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        adj    = {add3(sh_q[36:33]), add3(sh_q[32:29]), add3(sh_q[28:25]),
                  add3(sh_q[24:21]), add3(sh_q[20:17]), sh_q[16:0]};
        if (start) begin
            sh_d   = {20'd0, bin};
            cnt_d  = 5'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sh_d  = {adj[35:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd16) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = sh_q[36:17];

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 character LCD driver for the CPU display stage.
// Runs the power-up initialisation, then on each refresh request formats a
// 2x16 frame (mnemonic, register address, signed decimal value) and writes
// it over the 8-bit bus with timed E strobes.
// Optional macro LCD_HEX_EN: adds "0x" plus 4 hex digits of the raw value at
// line-2 chars 7-12; without it those chars are spaces.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   sinal_start       one-cycle refresh request
//   entrada_op[2:0]   opcode, entrada_end[3:0] register, entrada_valor[15:0] value
//   saida_dados[7:0]  LCD data bus, lcd_rs command/char select, lcd_rw = 0, lcd_e strobe
//   ocupado           high while initialising or refreshing
//   pronto            one-cycle pulse when a refresh completes
module lcd_hd44780_driver #(
    parameter int T_PWRUP  = 750000,
    parameter int T_E_HIGH = 25,
    parameter int T_CMD    = 2000,
    parameter int T_CLR    = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sinal_start,
    input  logic [2:0]  entrada_op,
    input  logic [3:0]  entrada_end,
    input  logic [15:0] entrada_valor,
    output logic [7:0]  saida_dados,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic        ocupado,
    output logic        pronto
);
    import lcd_pkg::*;

    // One shared down-the-phase timer, wide enough for the longest wait
    localparam int TW = $clog2(T_PWRUP + T_CLR + T_CMD + T_E_HIGH + 1);
    localparam logic [TW-1:0] PWRUP_LAST = TW'(T_PWRUP - 1);
    localparam logic [TW-1:0] EHIGH_LAST = TW'(T_E_HIGH - 1);
    localparam logic [TW-1:0] CMD_LAST   = TW'(T_CMD - 1);
    localparam logic [TW-1:0] CLR_LAST   = TW'(T_CLR - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0]    idx_q, idx_d;
    logic          pending_q, pending_d;
    logic [2:0]    op_q, op_d;
    logic [3:0]    addr_q, addr_d;
    logic [15:0]   val_q, val_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          e_q, e_d;
    logic          pronto_q, pronto_d;
    logic          conv_start_q, conv_start_d;

    logic          conv_done;
    logic [19:0]   bcd;
    logic [16:0]   mag;
    logic [TW-1:0] hold_last;
    logic          load;
    logic          capture;
    xfer_t         xb;

    // Computed at 17 bits so that -32768 has a representable magnitude
    assign mag = val_q[15] ? (17'd0 - {1'b1, val_q}) : {1'b0, val_q};

    bin_to_bcd17 u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start_q),
        .bin   (mag),
        .done  (conv_done),
        .bcd   (bcd)
    );

    function automatic xfer_t init_byte(input logic [5:0] i);
        xfer_t x;
        x.rs = 1'b0;
        case (i)
            6'd0, 6'd1: x.data = CMD_FUNC_SET;
            6'd2:       x.data = CMD_DISP_ON;
            6'd3:       x.data = CMD_CLEAR;
            default:    x.data = CMD_ENTRY;
        endcase
        return x;
    endfunction

    function automatic logic [7:0] line1_char(input logic [3:0] c);
        logic [7:0] ch;
        case (c)
            4'd0, 4'd1, 4'd2, 4'd3: ch = mnemonic_char(op_q, c[1:0]);
            4'd5:    ch = ASCII_LBR;
            4'd6:    ch = addr_q[3] ? ASCII_ZERO + 8'd1 : ASCII_ZERO;
            4'd7:    ch = addr_q[2] ? ASCII_ZERO + 8'd1 : ASCII_ZERO;
            4'd8:    ch = addr_q[1] ? ASCII_ZERO + 8'd1 : ASCII_ZERO;
            4'd9:    ch = addr_q[0] ? ASCII_ZERO + 8'd1 : ASCII_ZERO;
            4'd10:   ch = ASCII_RBR;
            default: ch = ASCII_SPACE;
        endcase
        return ch;
    endfunction

`ifdef LCD_HEX_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? ASCII_ZERO + {4'd0, n} : ASCII_A + {4'd0, n} - 8'd10;
    endfunction
`endif

    function automatic logic [7:0] line2_char(input logic [3:0] c);
        logic [7:0] ch;
        case (c)
            4'd0:    ch = val_q[15] ? ASCII_MINUS : ASCII_PLUS;
            4'd1:    ch = ASCII_ZERO + {4'd0, bcd[19:16]};
            4'd2:    ch = ASCII_ZERO + {4'd0, bcd[15:12]};
            4'd3:    ch = ASCII_ZERO + {4'd0, bcd[11:8]};
            4'd4:    ch = ASCII_ZERO + {4'd0, bcd[7:4]};
            4'd5:    ch = ASCII_ZERO + {4'd0, bcd[3:0]};
`ifdef LCD_HEX_EN
            4'd7:    ch = ASCII_ZERO;
            4'd8:    ch = ASCII_X;
            4'd9:    ch = hex_char(val_q[15:12]);
            4'd10:   ch = hex_char(val_q[11:8]);
            4'd11:   ch = hex_char(val_q[7:4]);
            4'd12:   ch = hex_char(val_q[3:0]);
`endif
            default: ch = ASCII_SPACE;
        endcase
        return ch;
    endfunction

    // Frame order: line-1 address, 16 chars, line-2 address, 16 chars
    function automatic xfer_t write_byte(input logic [5:0] i);
        xfer_t x;
        if (i == 6'd0) begin
            x = '{rs: 1'b0, data: CMD_LINE1};
        end else if (i <= 6'd16) begin
            x = '{rs: 1'b1, data: line1_char(4'(i - 6'd1))};
        end else if (i == 6'd17) begin
            x = '{rs: 1'b0, data: CMD_LINE2};
        end else begin
            x = '{rs: 1'b1, data: line2_char(4'(i - 6'd18))};
        end
        return x;
    endfunction

    // Next-state logic; data and RS are loaded on entry to SETUP so they are
    // already valid on the bus during the SETUP cycle and stay put until the
    // next byte is loaded
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        op_d         = op_q;
        addr_d       = addr_q;
        val_d        = val_q;
        data_d       = data_q;
        rs_d         = rs_q;
        e_d          = e_q;
        pronto_d     = 1'b0;
        conv_start_d = 1'b0;
        load         = 1'b0;
        capture      = 1'b0;
        xb           = '0;
        hold_last    = (!rs_q && data_q == CMD_CLEAR) ? CLR_LAST : CMD_LAST;

        // Requests arriving while busy collapse into one pending refresh
        if (sinal_start && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_PWRUP: begin
                if (timer_q == PWRUP_LAST) begin
                    state_d = S_INIT;
                    phase_d = P_SETUP;
                    timer_d = '0;
                    idx_d   = 6'd0;
                    load    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_INIT, S_WRITE: begin
                case (phase_q)
                    P_SETUP: begin
                        e_d     = 1'b1;
                        phase_d = P_EHIGH;
                        timer_d = '0;
                    end
                    P_EHIGH: begin
                        if (timer_q == EHIGH_LAST) begin
                            e_d     = 1'b0;
                            phase_d = P_HOLD;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                    P_HOLD: begin
                        if (timer_q == hold_last) begin
                            timer_d = '0;
                            phase_d = P_SETUP;
                            if (state_q == S_INIT && idx_q == 6'd4) begin
                                idx_d = 6'd0;
                                if (pending_q || sinal_start) begin
                                    capture = 1'b1;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else if (state_q == S_WRITE && idx_q == 6'd33) begin
                                idx_d    = 6'd0;
                                state_d  = S_DONE;
                                pronto_d = 1'b1;
                            end else begin
                                idx_d = idx_q + 6'd1;
                                load  = 1'b1;
                            end
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                    default: phase_d = P_SETUP;
                endcase
            end
            S_IDLE: begin
                if (sinal_start) begin
                    capture = 1'b1;
                end
            end
            S_CONV: begin
                if (conv_done) begin
                    state_d = S_WRITE;
                    phase_d = P_SETUP;
                    timer_d = '0;
                    idx_d   = 6'd0;
                    load    = 1'b1;
                end
            end
            S_DONE: begin
                if (pending_q || sinal_start) begin
                    capture = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_PWRUP;
        endcase

        // Starting a refresh always samples the inputs as they are now
        if (capture) begin
            op_d         = entrada_op;
            addr_d       = entrada_end;
            val_d        = entrada_valor;
            pending_d    = 1'b0;
            state_d      = S_CONV;
            conv_start_d = 1'b1;
        end

        if (load) begin
            xb     = (state_d == S_INIT) ? init_byte(idx_d) : write_byte(idx_d);
            data_d = xb.data;
            rs_d   = xb.rs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_PWRUP;
            phase_q      <= P_SETUP;
            timer_q      <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            val_q        <= '0;
            data_q       <= '0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            pronto_q     <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            val_q        <= val_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            e_q          <= e_d;
            pronto_q     <= pronto_d;
            conv_start_q <= conv_start_d;
        end
    end

    assign saida_dados = data_q;
    assign lcd_rs      = rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_e       = e_q;
    assign ocupado     = (state_q != S_IDLE);
    assign pronto      = pronto_q;

endmodule
